// File: rtl/synth_pkg.sv
// Shared constants and types for the NCO voice scheduler.
package synth_pkg;
  localparam int NUM_VOICES  = 8;
  localparam int VOICE_IDX_W = 3;
  localparam int PHASE_W     = 32;
  localparam int KEY_W       = 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/voice_alloc.sv
// Key match and lowest-free-voice priority encoder over the voice table.
module voice_alloc
  import synth_pkg::*;
(
  input  logic [NUM_VOICES-1:0]            active,
  input  logic [NUM_VOICES-1:0][KEY_W-1:0] keys,
  input  logic [KEY_W-1:0]                 key,
  output logic                             hit,
  output logic [VOICE_IDX_W-1:0]           hit_idx,
  output logic                             free,
  output logic [VOICE_IDX_W-1:0]           free_idx
);
  // Descending scan so the lowest matching index is the last write and wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && keys[i] == key) begin
        hit     = 1'b1;
        hit_idx = i[VOICE_IDX_W-1:0];
      end
      if (!active[i]) begin
        free     = 1'b1;
        free_idx = i[VOICE_IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/nco_voice_scheduler.sv
// Eight-voice NCO phase table: note on/off allocation plus a per-sample frame
// that steps each voice once and streams the pre-increment phases.
module nco_voice_scheduler
  import synth_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic                   note_on,
  input  logic                   note_off,
  input  logic [KEY_W-1:0]       note_key,
  input  logic [PHASE_W-1:0]     note_inc,
  output logic                   phase_valid,
  output logic [PHASE_W-1:0]     phase_out,
  output logic [VOICE_IDX_W-1:0] phase_voice,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   alloc_fail,
  output logic [NUM_VOICES-1:0]  active_mask
);
  logic [NUM_VOICES-1:0]              active_r;
  logic [NUM_VOICES-1:0][KEY_W-1:0]   key_r;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] inc_r;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_r;

  state_t                 state, state_nx;
  logic [VOICE_IDX_W-1:0] idx, idx_nx;

  logic                   hit, free;
  logic [VOICE_IDX_W-1:0] hit_idx, free_idx;
  logic                   ev_on, ev_off, step;

  voice_alloc u_alloc (
    .active   (active_r),
    .keys     (key_r),
    .key      (note_key),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .free     (free),
    .free_idx (free_idx)
  );

  assign ev_on  = note_on;
  assign ev_off = note_off & ~note_on;
  assign step   = (state == RUN) && active_r[idx];
  assign busy   = (state != IDLE);
  assign active_mask = active_r;

  // Note events are written after the step so they override it on the same voice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= '0;
      key_r    <= '0;
      inc_r    <= '0;
      phase_r  <= '0;
    end else begin
      if (step) phase_r[idx] <= phase_r[idx] + inc_r[idx];
      if (ev_on && hit) begin
        inc_r[hit_idx]   <= note_inc;
        phase_r[hit_idx] <= '0;
      end else if (ev_on && free) begin
        active_r[free_idx] <= 1'b1;
        key_r[free_idx]    <= note_key;
        inc_r[free_idx]    <= note_inc;
        phase_r[free_idx]  <= '0;
      end else if (ev_off && hit) begin
        active_r[hit_idx] <= 1'b0;
        phase_r[hit_idx]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: if (sample_tick) begin
        state_nx = RUN;
        idx_nx   = '0;
      end
      RUN: begin
        idx_nx = idx + 1'b1;
        if (idx == VOICE_IDX_W'(NUM_VOICES - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_valid <= 1'b0;
      phase_out   <= '0;
      phase_voice <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      alloc_fail  <= 1'b0;
    end else begin
      phase_valid <= step;
      phase_out   <= step ? phase_r[idx] : '0;
      phase_voice <= step ? idx : '0;
      frame_done  <= (state == DONE);
      overrun     <= sample_tick && busy;
      alloc_fail  <= ev_on && !hit && !free;
    end
  end
endmodule

// File: doc/nco_voice_scheduler.md
NCO_VOICE_SCHEDULER -- requirements
Module: nco_voice_scheduler

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: sample_tick  in  1  one-cycle pulse at 48 kHz sample rate.
REQ-004 SHALL provide: note_on  in  1  key-press event, valid for one cycle.
REQ-005 SHALL provide: note_off  in  1  key-release event, valid for one cycle.
REQ-006 SHALL provide: note_key  in  7  key number for note_on/note_off.
REQ-007 SHALL provide: note_inc  in  32  phase increment for note_on.
REQ-008 SHALL provide: phase_valid  out  1  phase_out/phase_voice valid this cycle.
REQ-009 SHALL provide: phase_out  out  32  voice phase, pre-increment, feeds waveform ROM.
REQ-010 SHALL provide: phase_voice  out  3  voice index of phase_out.
REQ-011 SHALL provide: frame_done  out  1  one-cycle pulse, all voices stepped.
REQ-012 SHALL provide: busy  out  1  frame in progress.
REQ-013 SHALL provide: overrun  out  1  one-cycle pulse, sample_tick dropped.
REQ-014 SHALL provide: alloc_fail  out  1  one-cycle pulse, note_on rejected.
REQ-015 SHALL provide: active_mask  out  8  per-voice active bits.

Function
REQ-016 SHALL hold 8 voice entries: active (1b), key (7b), inc (32b), phase (32b).
REQ-017 note_on, key matches active voice: SHALL retrigger that voice -- inc <= note_inc, phase <= 0.
REQ-018 note_on, no key match: SHALL allocate lowest-index inactive voice -- active=1, key, inc loaded, phase=0.
REQ-019 note_on, no match, all 8 active: table unchanged; alloc_fail pulses the following cycle.
REQ-020 note_off: SHALL clear active and zero phase of matching voice; no match -> ignored.
REQ-021 note_on and note_off same cycle: note_on SHALL be processed, note_off ignored.
REQ-022 Note events SHALL take effect the cycle after assertion; active_mask registered, reflects table.
REQ-023 FSM states IDLE, RUN, DONE; IDLE->RUN on sample_tick with idx=0; RUN advances idx every cycle; RUN->DONE after idx 7; DONE->IDLE unconditionally.
REQ-024 RUN SHALL take exactly 8 cycles regardless of active voices.
REQ-025 RUN, voice idx active: registered next cycle phase_valid=1, phase_out=phase, phase_voice=idx; phase <= phase + inc mod 2^32 (carry discarded).
REQ-026 RUN, voice idx inactive: phase_valid=0 next cycle; phase untouched.
REQ-027 Timing, tick at cycle T: RUN T+1..T+8; voice i output in cycle T+2+i; DONE T+9; frame_done in T+10.
REQ-028 busy SHALL equal (state != IDLE), i.e. high T+1..T+9.
REQ-029 sample_tick while busy: ignored; overrun pulses next cycle; running frame unaffected.
REQ-030 Note event and RUN step targeting same voice same cycle: note event SHALL win (phase=0, no increment).
REQ-031 phase_out/phase_voice SHALL be 0 whenever phase_valid=0.

Reset
REQ-032 rst low SHALL asynchronously clear all voice fields, idx, FSM to IDLE, all outputs to 0.
REQ-033 rst asserted mid-frame SHALL abort the frame with no frame_done; first tick after release starts a fresh frame.

Structure
REQ-034 Shared package synth_pkg SHALL hold NUM_VOICES=8, VOICE_IDX_W=3, PHASE_W=32, KEY_W=7, FSM state enum.
REQ-035 SHALL instantiate one sub-module voice_alloc: combinational key match + lowest-free priority encoder returning hit, free, index.

Verification
REQ-036 Reset; note_on key 60 inc 0x0100_0000; three ticks -> voice 0 phase_out 0x0, 0x0100_0000, 0x0200_0000 at T+2; frame_done at T+10.
REQ-037 Wrap: inc 0x8000_0000, three ticks -> phase_out 0x0, 0x8000_0000, 0x0.
REQ-038 note_on keys 60..67 -> active_mask 0xFF; key 68 -> alloc_fail pulse, mask 0xFF; note_off 62 -> 0xFB; note_on 68 -> voice 2, mask 0xFF.
REQ-039 Retrigger key 60 with inc 0x0200_0000 after 2 frames -> same voice, next output 0x0, then 0x0200_0000.
REQ-040 Tick at T, second tick at T+3 -> overrun at T+4; one frame_done at T+10 only.
REQ-041 rst low at T+4 -> all outputs 0, mask 0x00 immediately; subsequent tick -> no phase_valid, frame_done at T'+10.
